// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Collects completion results from the execute FUs (0 ALU, 1 SLS, 2 BR,
//   3 MLS, 4 GEMM) into one-entry holding buffers and round-robin arbitrates
//   them onto the single scalar regfile write port. Every grant also returns a
//   completion code to the issue stage so it can free the matching FUST row.
//
// Ports
//   CLK, nRST    clock; asynchronous active-low reset
//   fu_valid     FU i presents a completed result
//   fu_ready     buffer i accepts (transfer = fu_valid & fu_ready)
//   fu_wen       result writes a scalar register
//   fu_spec      result was issued under an unresolved branch
//   fu_rd        destination register per FU (REG_W bits each)
//   fu_wdata     write data per FU (DATA_W bits each)
//   wb_block     issue-stage WAR hold per buffer
//   branch_miss  misprediction flush
//   s_rw_en      regfile write enable (registered pulse)
//   s_rw         regfile write index
//   s_wdata      regfile write data
//   fu_ex        completion code: 0 NONE, 1 ALU, 2 SLS, 3 BR, 4 MLS, 5 GEMM
//   wb_busy      at least one holding buffer is valid
module writeback_arbiter #(
  parameter int NUM_FU = 5,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_FU-1:0]         fu_valid,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic [NUM_FU-1:0]         fu_wen,
  input  logic [NUM_FU-1:0]         fu_spec,
  input  logic [NUM_FU*REG_W-1:0]   fu_rd,
  input  logic [NUM_FU*DATA_W-1:0]  fu_wdata,
  input  logic [NUM_FU-1:0]         wb_block,
  input  logic                      branch_miss,
  output logic                      s_rw_en,
  output logic [REG_W-1:0]          s_rw,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [2:0]                fu_ex,
  output logic                      wb_busy
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Completion code is the FU index plus one; zero is reserved for NONE.
  function automatic logic [2:0] fu_code(input logic [PTR_W-1:0] idx);
    return 3'(idx) + 3'd1;
  endfunction

  logic [NUM_FU-1:0] buf_vld_p0;
  logic [NUM_FU-1:0] buf_wen_p0;
  logic [NUM_FU-1:0] buf_spec_p0;
  logic [REG_W-1:0]  buf_rd_p0    [NUM_FU];
  logic [DATA_W-1:0] buf_wdata_p0 [NUM_FU];
  logic [PTR_W-1:0]  rr_ptr;

  logic [NUM_FU-1:0] flush_mask;
  logic [NUM_FU-1:0] cand;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] take;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  scan_ptr;
  int                scan_idx;

  logic              rw_en_p1;
  logic [REG_W-1:0]  rw_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [2:0]        ex_p1;

  // ---- Stage p0: holding buffers and arbitration on registered state ----
  assign flush_mask = {NUM_FU{branch_miss}};
  assign cand       = buf_vld_p0 & ~wb_block & ~(flush_mask & buf_spec_p0);
  assign fu_ready   = ~buf_vld_p0 | grant;
  // Speculative arrivals during a flush are accepted but never captured.
  assign take       = fu_valid & fu_ready & ~(flush_mask & fu_spec);
  assign wb_busy    = |buf_vld_p0;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    scan_ptr  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
      scan_ptr = PTR_W'(scan_idx);
      if (!grant_any && cand[scan_ptr]) begin
        grant_any = 1'b1;
        grant_idx = scan_ptr;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // A new capture wins over the grant/flush clear of the same slot, which is
  // what lets an entry leave and be replaced in the same cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_vld_p0 <= '0;
      rr_ptr     <= '0;
    end else begin
      buf_vld_p0 <= take | (buf_vld_p0 & ~grant & ~(flush_mask & buf_spec_p0));
      if (grant_any)
        rr_ptr <= (grant_idx == PTR_W'(NUM_FU-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (take[i]) begin
        buf_wen_p0[i]   <= fu_wen[i];
        buf_spec_p0[i]  <= fu_spec[i];
        buf_rd_p0[i]    <= fu_rd[i*REG_W +: REG_W];
        buf_wdata_p0[i] <= fu_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---- Stage p1: registered writeback / completion pulse ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rw_en_p1 <= 1'b0;
      rw_p1    <= '0;
      wdata_p1 <= '0;
      ex_p1    <= '0;
    end else if (grant_any) begin
      // r0 is hardwired, so a write to it still completes but never writes.
      rw_en_p1 <= buf_wen_p0[grant_idx] & (buf_rd_p0[grant_idx] != '0);
      rw_p1    <= buf_rd_p0[grant_idx];
      wdata_p1 <= buf_wdata_p0[grant_idx];
      ex_p1    <= fu_code(grant_idx);
    end else begin
      rw_en_p1 <= 1'b0;
      rw_p1    <= '0;
      wdata_p1 <= '0;
      ex_p1    <= '0;
    end
  end

  assign s_rw_en = rw_en_p1;
  assign s_rw    = rw_p1;
  assign s_wdata = wdata_p1;
  assign fu_ex   = ex_p1;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed bench for writeback_arbiter: a table of one-cycle vectors with
//   hand-computed fu_ready (before the edge) and registered outputs (after the
//   edge), followed by a hand-written reset-in-flight sequence.
module tb_writeback_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int RW = 5;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [N-1:0]    fu_valid, fu_ready, fu_wen, fu_spec, wb_block;
  logic [N*RW-1:0] fu_rd;
  logic [N*DW-1:0] fu_wdata;
  logic            branch_miss;
  logic            s_rw_en;
  logic [RW-1:0]   s_rw;
  logic [DW-1:0]   s_wdata;
  logic [2:0]      fu_ex;
  logic            wb_busy;

  always #5 CLK = ~CLK;

  writeback_arbiter #(.NUM_FU(N), .DATA_W(DW), .REG_W(RW)) dut (
    .CLK(CLK), .nRST(nRST),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_wen(fu_wen), .fu_spec(fu_spec),
    .fu_rd(fu_rd), .fu_wdata(fu_wdata), .wb_block(wb_block), .branch_miss(branch_miss),
    .s_rw_en(s_rw_en), .s_rw(s_rw), .s_wdata(s_wdata), .fu_ex(fu_ex), .wb_busy(wb_busy)
  );

  typedef struct {
    logic [4:0]  vld, wen, spec, blk;
    logic        bm;
    logic [4:0]  rdb;
    logic [31:0] wdb;
    logic [4:0]  e_rdy;
    logic        e_en;
    logic [4:0]  e_rw;
    logic [31:0] e_wd;
    logic [2:0]  e_ex;
    logic        e_busy;
  } vec_t;

  vec_t tbl [20];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [4:0] vld, wen, spec, blk, input logic bm,
                              input logic [4:0] rdb, input logic [31:0] wdb,
                              input logic [4:0] e_rdy, input logic e_en, input logic [4:0] e_rw,
                              input logic [31:0] e_wd, input logic [2:0] e_ex, input logic e_busy);
    vec_t v;
    v.vld = vld; v.wen = wen; v.spec = spec; v.blk = blk; v.bm = bm;
    v.rdb = rdb; v.wdb = wdb; v.e_rdy = e_rdy; v.e_en = e_en; v.e_rw = e_rw;
    v.e_wd = e_wd; v.e_ex = e_ex; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FU i gets rd = rdb+i and wdata = wdb+i so each source is distinguishable.
  task automatic drive(input logic [4:0] vld, wen, spec, blk, input logic bm,
                       input logic [4:0] rdb, input logic [31:0] wdb);
    fu_valid = vld; fu_wen = wen; fu_spec = spec; wb_block = blk; branch_miss = bm;
    for (int i = 0; i < N; i++) begin
      fu_rd[i*RW +: RW]    = rdb + 5'(i);
      fu_wdata[i*DW +: DW] = wdb + 32'(i);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [4:0] rw,
                         input logic [31:0] wd, input logic [2:0] ex, input logic busy);
    chk({tag, ".s_rw_en"}, 32'(s_rw_en), 32'(en));
    chk({tag, ".s_rw"},    32'(s_rw),    32'(rw));
    chk({tag, ".s_wdata"}, s_wdata,      wd);
    chk({tag, ".fu_ex"},   32'(fu_ex),   32'(ex));
    chk({tag, ".wb_busy"}, 32'(wb_busy), 32'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    //            vld       wen       spec      blk       bm  rdb  wdb             rdy       en rw  wd             ex busy
    tbl[0]  = mk(5'b00001, 5'b11111, 5'b00000, 5'b00000, 0, 5,  32'hDEADBEEF,   5'b11111, 0, 0,  32'h0,         0, 1);
    tbl[1]  = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 1, 5,  32'hDEADBEEF,  1, 0);
    tbl[2]  = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 0, 0,  32'h0,         0, 0);
    tbl[3]  = mk(5'b10000, 5'b11111, 5'b00000, 5'b00000, 0, 10, 32'h100,        5'b11111, 0, 0,  32'h0,         0, 1);
    tbl[4]  = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 1, 14, 32'h104,       5, 0);
    tbl[5]  = mk(5'b00111, 5'b00011, 5'b00000, 5'b00000, 0, 1,  32'h1000,       5'b11111, 0, 0,  32'h0,         0, 1);
    tbl[6]  = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11001, 1, 1,  32'h1000,      1, 1);
    tbl[7]  = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11011, 1, 2,  32'h1001,      2, 1);
    tbl[8]  = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 0, 3,  32'h1002,      3, 0);
    tbl[9]  = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 0, 0,  32'h0,         0, 0);
    tbl[10] = mk(5'b01000, 5'b11111, 5'b00000, 5'b00000, 0, 29, 32'h55,         5'b11111, 0, 0,  32'h0,         0, 1);
    tbl[11] = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 0, 0,  32'h58,        4, 0);
    tbl[12] = mk(5'b00010, 5'b11111, 5'b00000, 5'b00010, 0, 8,  32'h200,        5'b11111, 0, 0,  32'h0,         0, 1);
    tbl[13] = mk(5'b00001, 5'b11111, 5'b00000, 5'b00010, 0, 8,  32'h300,        5'b11101, 0, 0,  32'h0,         0, 1);
    tbl[14] = mk(5'b00001, 5'b11111, 5'b00000, 5'b00010, 0, 16, 32'h400,        5'b11101, 1, 8,  32'h300,       1, 1);
    tbl[15] = mk(5'b00000, 5'b00000, 5'b00000, 5'b00010, 0, 0,  32'h0,          5'b11101, 1, 16, 32'h400,       1, 1);
    tbl[16] = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 1, 9,  32'h201,       2, 0);
    tbl[17] = mk(5'b00101, 5'b11111, 5'b00001, 5'b00000, 0, 4,  32'h600,        5'b11111, 0, 0,  32'h0,         0, 1);
    tbl[18] = mk(5'b00010, 5'b11111, 5'b00011, 5'b00000, 1, 0,  32'h0,          5'b11110, 1, 6,  32'h602,       3, 0);
    tbl[19] = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0,  32'h0,          5'b11111, 0, 0,  32'h0,         0, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.fu_ready", 32'(fu_ready), 32'h1F);
    nRST = 1'b1;

    for (int v = 0; v < 20; v++) begin
      drive(tbl[v].vld, tbl[v].wen, tbl[v].spec, tbl[v].blk, tbl[v].bm, tbl[v].rdb, tbl[v].wdb);
      #1;
      chk($sformatf("vec%0d.fu_ready", v), 32'(fu_ready), 32'(tbl[v].e_rdy));
      tick();
      chk_out($sformatf("vec%0d", v), tbl[v].e_en, tbl[v].e_rw, tbl[v].e_wd, tbl[v].e_ex, tbl[v].e_busy);
    end

    // Reset with three buffers valid and a completion pulse on the outputs.
    drive(5'b00111, 5'b11111, 0, 0, 0, 7, 32'h700);
    tick();
    chk("rstseq.busy_loaded", 32'(wb_busy), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rstseq.pre_ex", 32'(fu_ex), 32'd1);
    chk("rstseq.pre_rw", 32'(s_rw), 32'd7);
    nRST = 1'b0;
    #1;
    chk_out("rstseq.async", 0, 0, 0, 0, 0);
    chk("rstseq.fu_ready", 32'(fu_ready), 32'h1F);
    #1;
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("rstseq.idle%0d", c), 0, 0, 0, 0, 0);
    end
    // rr_ptr back at 0: ALU must win over GEMM.
    drive(5'b10001, 5'b11111, 0, 0, 0, 3, 32'h900);
    tick();
    chk("rstseq.busy_new", 32'(wb_busy), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("rstseq.first", 1, 3, 32'h900, 1, 1);
    tick();
    chk_out("rstseq.second", 1, 7, 32'h904, 5, 0);
    tick();
    chk_out("rstseq.done", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
